// File: rtl/montgomery_pkg.sv
// Shared constants and types for the q = 3329 Montgomery multiplier (R = 2^12).
package montgomery_pkg;

   localparam int W           = 12;
   localparam int Q           = 3329;
   localparam int QINV_NEG    = 3327;
   localparam int R_INV_MOD_Q = 2704;
   localparam int R_MOD_Q     = 767;
   localparam int LAT         = 3;

   typedef logic [W-1:0]   coef_t;
   typedef logic [2*W-1:0] prod_t;
   typedef logic [2*W:0]   sum_t;
   typedef logic [W:0]     red_t;

   localparam red_t Q_EXT = red_t'(Q);

   // u < 2Q for in-range operands, so a single conditional subtract fully reduces
   function automatic coef_t cond_sub_q(input red_t u);
      return (u >= Q_EXT) ? coef_t'(u - Q_EXT) : coef_t'(u);
   endfunction

endpackage

// File: rtl/montgomery_reduce.sv
// Montgomery reduction of a 24-bit product: quotient stage then add/shift/subtract stage.
module montgomery_reduce
   import montgomery_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  prod_t t_i,
   input  logic  valid_i,
   output coef_t r_o,
   output logic  valid_o,
   output logic  busy_o
);

   prod_t t2_q, t2_d;
   coef_t m_q, m_d;
   logic  v2_q, v2_d;
   coef_t r_q, r_d;
   logic  vo_q, vo_d;

   sum_t  sum_w;
   red_t  u_w;

   always_comb begin
      t2_d = t2_q;
      m_d  = m_q;
      v2_d = valid_i;
      if (valid_i) begin
         t2_d = t_i;
         m_d  = t_i[W-1:0] * coef_t'(QINV_NEG);
      end
   end

   // Low W bits of the sum are zero by choice of m; only the shifted part is kept
   always_comb begin
      sum_w = sum_t'(t2_q) + sum_t'(m_q) * sum_t'(Q);
      u_w   = red_t'(sum_w >> W);
   end

   always_comb begin
      r_d  = r_q;
      vo_d = v2_q;
      if (v2_q) begin
         r_d = cond_sub_q(u_w);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t2_q <= '0;
         m_q  <= '0;
         v2_q <= 1'b0;
         r_q  <= '0;
         vo_q <= 1'b0;
      end else begin
         t2_q <= t2_d;
         m_q  <= m_d;
         v2_q <= v2_d;
         r_q  <= r_d;
         vo_q <= vo_d;
      end
   end

   assign r_o     = r_q;
   assign valid_o = vo_q;
   assign busy_o  = v2_q | vo_q;

endmodule

// File: rtl/montgomery_top.sv
// Streaming 12-bit Montgomery multiplier: r = a*b*R^-1 mod 3329, one pair per clock, latency 3.
module montgomery_top
   import montgomery_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] r
);

   coef_t a_q, a_d;
   coef_t b_q, b_d;
   logic  v0_q, v0_d;
   prod_t t_q, t_d;
   logic  v1_q, v1_d;
   logic  red_busy;

   // Operands are captured first so the multiplier sees registered inputs
   always_comb begin
      a_d  = a_q;
      b_d  = b_q;
      v0_d = en;
      if (en) begin
         a_d = a;
         b_d = b;
      end
   end

   always_comb begin
      t_d  = t_q;
      v1_d = v0_q;
      if (v0_q) begin
         t_d = prod_t'(a_q) * prod_t'(b_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= '0;
         b_q  <= '0;
         v0_q <= 1'b0;
         t_q  <= '0;
         v1_q <= 1'b0;
      end else begin
         a_q  <= a_d;
         b_q  <= b_d;
         v0_q <= v0_d;
         t_q  <= t_d;
         v1_q <= v1_d;
      end
   end

   montgomery_reduce u_reduce (
      .clk     (clk),
      .rst_n   (rst_n),
      .t_i     (t_q),
      .valid_i (v1_q),
      .r_o     (r),
      .valid_o (done),
      .busy_o  (red_busy)
   );

   assign busy = en | v0_q | v1_q | red_busy;

endmodule

// File: tb/tb_montgomery_top.sv
// Self-checking bench for montgomery_top against a plain modular-arithmetic reference.
module tb_montgomery_top;

   localparam int QM   = 3329;
   localparam int RINV = 2704;
   localparam int LATC = 3;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [11:0] a;
   logic [11:0] b;
   logic        busy;
   logic        done;
   logic [11:0] r;

   typedef struct {
      int          due;
      logic [11:0] res;
   } exp_t;

   exp_t        q[$];
   int          cyc;
   int          checks;
   int          errors;
   logic [11:0] last_r;

   montgomery_top dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .r     (r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] gold(input int x, input int y);
      longint p;
      p = (longint'(x) * longint'(y) * longint'(RINV)) % longint'(QM);
      return 12'(p);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Compares done/r/busy against the queue of outstanding transactions
   task automatic observe();
      logic exp_done;
      logic exp_busy;
      exp_done = (q.size() > 0) && (q[0].due == cyc);
      exp_busy = en | (q.size() > 0);
      check("done", 32'(done), 32'(exp_done));
      check("busy", 32'(busy), 32'(exp_busy));
      if (exp_done) begin
         check("r", 32'(r), 32'(q[0].res));
         last_r = q[0].res;
         void'(q.pop_front());
      end else begin
         check("r_hold", 32'(r), 32'(last_r));
      end
   endtask

   task automatic tick(input logic e, input int x, input int y);
      en = e;
      a  = 12'(x);
      b  = 12'(y);
      @(posedge clk);
      cyc++;
      if (e) q.push_back('{due: cyc + LATC, res: gold(x, y)});
      @(negedge clk);
      observe();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 0, 0);
   endtask

   initial begin
      int x;
      int y;
      checks = 0;
      errors = 0;
      cyc    = 0;
      last_r = '0;
      rst_n  = 1'b0;
      en     = 1'b0;
      a      = '0;
      b      = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_r",    32'(r),    32'd0);
      rst_n = 1'b1;
      idle(2);

      tick(1'b1, 1, 1);
      idle(5);

      tick(1'b1, 767, 5);
      tick(1'b1, 1, 767);
      tick(1'b1, 0, 1234);
      tick(1'b1, 3328, 3328);
      tick(1'b1, 3328, 1);
      tick(1'b1, 2000, 0);
      idle(5);

      for (int i = 0; i < 512; i++) begin
         x = int'($urandom_range(QM - 1));
         y = int'($urandom_range(QM - 1));
         tick(1'b1, x, y);
      end
      idle(5);

      tick(1'b1, int'($urandom_range(QM - 1)), int'($urandom_range(QM - 1)));
      tick(1'b0, 0, 0);
      tick(1'b1, int'($urandom_range(QM - 1)), int'($urandom_range(QM - 1)));
      tick(1'b1, int'($urandom_range(QM - 1)), int'($urandom_range(QM - 1)));
      tick(1'b0, 0, 0);
      idle(5);

      for (int i = 0; i < 64; i++) begin
         x = int'($urandom_range(QM - 1));
         y = int'($urandom_range(QM - 1));
         tick(1'($urandom_range(1)), x, y);
      end
      idle(5);

      tick(1'b1, 1234, 2345);
      tick(1'b1, 3000, 17);
      rst_n = 1'b0;
      en    = 1'b0;
      #1;
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_r",    32'(r),    32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      q.delete();
      last_r = '0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(6);

      tick(1'b1, 767, 3328);
      idle(5);

      check("queue_drained", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/montgomery_top.md
Name: montgomery_top

Overview:
- Fully pipelined 12-bit Montgomery modular multiplier for modulus q = 3329, with Montgomery radix R = 2^12 = 4096.
- Computes r = a·b·R^-1 mod q, fully reduced to [0, q-1].
- Accepts one operand pair per clock while en is high and returns results in issue order with a fixed latency.
- Sits in the polynomial-arithmetic datapath as a streaming coefficient multiplier.

Parameters:
- Q, 3329, modulus (odd, < 2^12).
- W, 12, operand/result width; R = 2^W.
- QINV_NEG, 3327, −Q^-1 mod 2^W (Q·769 ≡ 1 mod 4096).
- LAT, 3, input-to-output latency in clock cycles.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  operand-valid; a/b sampled on every rising edge where en=1.
- a  input  12  multiplicand, must be in [0, Q-1].
- b  input  12  multiplier, must be in [0, Q-1].
- busy  output  1  high while any operation is in flight or being accepted.
- done  output  1  one-cycle result-valid strobe per accepted pair.
- r  output  12  result a·b·R^-1 mod Q, valid when done=1.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: done=0, busy=0, r=0, all pipeline valid bits cleared. Reset asserted mid-operation discards all in-flight operations; no done is produced for them.
- Throughput: 1 pair/cycle, no stall, no backpressure. en may stay high indefinitely or toggle arbitrarily; each en=1 edge yields exactly one done.
- Latency: pair sampled at edge k → done=1 with r valid after edge k+LAT (3). Results are strictly in issue order.
- Stage 1: t = a·b (24-bit unsigned), registered with valid.
- Stage 2: m = (t[11:0] · QINV_NEG) mod 2^12 (low 12 bits only); register t and m.
- Stage 3: u = (t + m·Q) >> 12; the sum is 25 bits and its low 12 bits are zero by construction. u < 2Q. Register r = (u ≥ Q) ? u − Q : u, and done = stage-2 valid.
- done is a registered copy of the valid pipeline; r holds its last value when done=0 (not cleared).
- busy = en | OR of all stage valid bits (combinational from registers and en).
- Inputs ≥ Q: result is unspecified but must remain 12-bit with no X; the bench does not check it.
- Boundary cases: a=0 or b=0 → r=0; a=b=Q−1 → r=R^-1 mod Q = 2704.

Decomposition:
- Shared package montgomery_pkg: constants Q=3329, W=12, QINV_NEG=3327, R_INV_MOD_Q=2704, R_MOD_Q=767.
- One natural sub-module: montgomery_reduce (t, valid in → r, valid out; stages 2–3). The top holds the multiply stage and the busy logic.

Test Plan:
- Reset, then single pair a=1, b=1 with en for 1 cycle → exactly one done, 3 cycles later, r=2704; busy high from issue until done.
- a=767 (R mod q), b=5 → r=5; a=1, b=767 → r=1; a=0, b=1234 → r=0.
- a=3328, b=3328 → r=2704; a=3328, b=1 → r=Q−2704=625 (since −R^-1 mod q).
- Back-to-back stream of 512 random pairs in [0, 3328], en held high → 512 done pulses in order, each r equal to the golden model (a·b·2704) mod 3329; no gaps after fill.
- en toggled 1,0,1,1,0 → done pattern identical, delayed 3 cycles; busy drops to 0 one cycle after the final done.
- rst_n asserted while 2 operations are in flight → done=0 and r=0 immediately; no done pulses after release until new en.
